code_lock_param: RTL and testbench

Parametrised successor to the fixed six-digit sequence lock. Accepts strobed digits from the keypad front-end, compares a complete entry against a programmable code register, and counts failed attempts toward a timed lockout. When open, it accepts a new code in programming mode. It drives the lock actuator and the two-bit status display consumed by the board display decoder.

---
 rtl/code_lock_param.sv | 190 +++++++++++++++++++
 tb/tb_code_lock_param.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_param.sv
// Parametrised keypad code lock: programmable code, failed-attempt counter,
// timed lockout and in-place reprogramming while open.
module code_lock_param #(
    parameter int DIGIT_W        = 4,
    parameter int CODE_LEN       = 6,
    parameter int MAX_ERRORS     = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 24'h575164
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            digit_valid,
    input  logic [DIGIT_W-1:0]              digit,
    input  logic                            clear,
    input  logic                            prog_req,
    output logic                            unlocked,
    output logic                            error_led,
    output logic                            lockout,
    output logic                            prog_active,
    output logic [1:0]                      state_display,
    output logic [$clog2(MAX_ERRORS+1)-1:0] err_count
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int POS_W  = $clog2(CODE_LEN);
    localparam int ERR_W  = $clog2(MAX_ERRORS + 1);
    localparam int CNT_W  = $clog2(LOCKOUT_CYCLES);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(CODE_LEN - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(MAX_ERRORS);
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(MAX_ERRORS - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_OPEN,
        ST_LOCKOUT,
        ST_PROG
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   shadow_q, shadow_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                mis_q, mis_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          disp_d;

    logic [DIGIT_W-1:0]  slot;
    logic [CODE_W-1:0]   shadow_ins;
    logic                last;
    logic                miss;

    // Slot at the current position, first digit in the MSBs.
    always_comb begin
        slot       = '0;
        shadow_ins = shadow_q;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (pos_q == POS_W'(i)) begin
                slot = code_q[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
                shadow_ins[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit;
            end
        end
    end

    assign last = (pos_q == LAST_POS);
    assign miss = mis_q | (digit != slot);

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        shadow_d = shadow_q;
        pos_d    = pos_q;
        mis_d    = mis_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_ENTRY: begin
                if (clear) begin
                    pos_d = '0;
                    mis_d = 1'b0;
                end else if (digit_valid) begin
                    if (last) begin
                        pos_d = '0;
                        mis_d = 1'b0;
                        if (!miss) begin
                            state_d = ST_OPEN;
                            err_d   = '0;
                        end else if (err_q == ERR_LAST) begin
                            state_d = ST_LOCKOUT;
                            cnt_d   = CNT_INIT;
                            err_d   = ERR_MAX;
                        end else begin
                            err_d = err_q + ERR_W'(1);
                        end
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                        mis_d = miss;
                    end
                end
            end
            ST_OPEN: begin
                if (clear) begin
                    state_d = ST_ENTRY;
                    pos_d   = '0;
                    mis_d   = 1'b0;
                end else if (prog_req) begin
                    state_d  = ST_PROG;
                    pos_d    = '0;
                    shadow_d = '0;
                end
            end
            ST_PROG: begin
                if (clear) begin
                    state_d = ST_ENTRY;
                    pos_d   = '0;
                    mis_d   = 1'b0;
                end else if (digit_valid) begin
                    shadow_d = shadow_ins;
                    if (last) begin
                        code_d  = shadow_ins;
                        state_d = ST_ENTRY;
                        pos_d   = '0;
                        mis_d   = 1'b0;
                        err_d   = '0;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end
            end
            ST_LOCKOUT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ENTRY;
                    err_d   = '0;
                    pos_d   = '0;
                    mis_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    always_comb begin
        disp_d = 2'b00;
        unique case (1'b1)
            (state_d == ST_LOCKOUT): disp_d = 2'b11;
            (state_d == ST_OPEN),
            (state_d == ST_PROG):    disp_d = 2'b10;
            default:                 disp_d = (err_d != '0) ? 2'b01 : 2'b00;
        endcase
    end

    // Outputs are registered from the next-state decode: same timing as a
    // Moore decode of state_q, but glitch-free at the pins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_ENTRY;
            code_q        <= DEFAULT_CODE;
            shadow_q      <= '0;
            pos_q         <= '0;
            mis_q         <= 1'b0;
            err_q         <= '0;
            cnt_q         <= '0;
            unlocked      <= 1'b0;
            error_led     <= 1'b0;
            lockout       <= 1'b0;
            prog_active   <= 1'b0;
            state_display <= 2'b00;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            shadow_q      <= shadow_d;
            pos_q         <= pos_d;
            mis_q         <= mis_d;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
            unlocked      <= (state_d == ST_OPEN);
            error_led     <= (err_d != '0) || (state_d == ST_LOCKOUT);
            lockout       <= (state_d == ST_LOCKOUT);
            prog_active   <= (state_d == ST_PROG);
            state_display <= disp_d;
        end
    end

    assign err_count = err_q;

endmodule

// File: tb/tb_code_lock_param.sv
// Directed bench for code_lock_param: vector table plus lockout, programming
// and reset corner sequences.
module tb_code_lock_param;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       digit_valid;
    logic [3:0] digit;
    logic       clear;
    logic       prog_req;
    logic       unlocked;
    logic       error_led;
    logic       lockout;
    logic       prog_active;
    logic [1:0] state_display;
    logic [1:0] err_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       dv;
        logic [3:0] d;
        logic       clr;
        logic       pr;
        logic       unl;
        logic       led;
        logic       lk;
        logic       pg;
        logic [1:0] sd;
        logic [1:0] ec;
    } vec_t;

    vec_t vecs[$];

    code_lock_param dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .digit_valid   (digit_valid),
        .digit         (digit),
        .clear         (clear),
        .prog_req      (prog_req),
        .unlocked      (unlocked),
        .error_led     (error_led),
        .lockout       (lockout),
        .prog_active   (prog_active),
        .state_display (state_display),
        .err_count     (err_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    // Starts and ends at a falling edge; spans exactly one rising edge.
    task automatic apply(input logic dv, input logic [3:0] d,
                         input logic clr, input logic pr);
        digit_valid = dv;
        digit       = d;
        clear       = clr;
        prog_req    = pr;
        @(posedge clock);
        #1;
        digit_valid = 1'b0;
        digit       = 4'd0;
        clear       = 1'b0;
        prog_req    = 1'b0;
        @(negedge clock);
    endtask

    task automatic enter(input logic [23:0] code);
        for (int i = 0; i < 6; i++)
            apply(1'b1, code[23-4*i -: 4], 1'b0, 1'b0);
    endtask

    task automatic check(input string nm, input logic unl, input logic led,
                         input logic lk, input logic pg,
                         input logic [1:0] sd, input logic [1:0] ec);
        logic [7:0] act;
        logic [7:0] exp;
        act = {unlocked, error_led, lockout, prog_active,
               state_display, err_count};
        exp = {unl, led, lk, pg, sd, ec};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got unl=%b led=%b lk=%b pg=%b sd=%b ec=%0d want unl=%b led=%b lk=%b pg=%b sd=%b ec=%0d",
                     nm, unlocked, error_led, lockout, prog_active,
                     state_display, err_count, unl, led, lk, pg, sd, ec);
        end
    endtask

    task automatic add(input logic dv, input logic [3:0] d, input logic clr,
                       input logic pr, input logic unl, input logic led,
                       input logic lk, input logic pg,
                       input logic [1:0] sd, input logic [1:0] ec);
        vec_t v;
        v = '{dv, d, clr, pr, unl, led, lk, pg, sd, ec};
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] dflt[6];
        dflt = '{4'd5, 4'd7, 4'd5, 4'd1, 4'd6, 4'd4};

        // correct default code, response only after the sixth digit
        for (int i = 0; i < 5; i++)
            add(1, dflt[i], 0, 0, 0, 0, 0, 0, 2'b00, 2'd0);
        add(1, 4'd4, 0, 0, 1, 0, 0, 0, 2'b10, 2'd0);
        add(0, 4'd0, 1, 0, 0, 0, 0, 0, 2'b00, 2'd0);
        // wrong third digit, no early verdict
        add(1, 4'd5, 0, 0, 0, 0, 0, 0, 2'b00, 2'd0);
        add(1, 4'd7, 0, 0, 0, 0, 0, 0, 2'b00, 2'd0);
        add(1, 4'd0, 0, 0, 0, 0, 0, 0, 2'b00, 2'd0);
        add(1, 4'd1, 0, 0, 0, 0, 0, 0, 2'b00, 2'd0);
        add(1, 4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 2'd0);
        add(1, 4'd4, 0, 0, 0, 1, 0, 0, 2'b01, 2'd1);
        // clear with a strobe drops the digit
        add(1, 4'd5, 1, 0, 0, 1, 0, 0, 2'b01, 2'd1);
        // three digits then abort
        add(1, 4'd5, 0, 0, 0, 1, 0, 0, 2'b01, 2'd1);
        add(1, 4'd7, 0, 0, 0, 1, 0, 0, 2'b01, 2'd1);
        add(1, 4'd5, 0, 0, 0, 1, 0, 0, 2'b01, 2'd1);
        add(0, 4'd0, 1, 0, 0, 1, 0, 0, 2'b01, 2'd1);
        for (int i = 0; i < 5; i++)
            add(1, dflt[i], 0, 0, 0, 1, 0, 0, 2'b01, 2'd1);
        add(1, 4'd4, 0, 0, 1, 0, 0, 0, 2'b10, 2'd0);
        // digits ignored while open, then relock
        add(0, 4'd0, 0, 0, 1, 0, 0, 0, 2'b10, 2'd0);
        add(1, 4'd3, 0, 0, 1, 0, 0, 0, 2'b10, 2'd0);
        add(0, 4'd0, 1, 0, 0, 0, 0, 0, 2'b00, 2'd0);

        reset_n     = 1'b0;
        digit_valid = 1'b0;
        digit       = 4'd0;
        clear       = 1'b0;
        prog_req    = 1'b0;
        repeat (2) @(negedge clock);
        check("reset", 0, 0, 0, 0, 2'b00, 2'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].dv, vecs[i].d, vecs[i].clr, vecs[i].pr);
            check($sformatf("vec%0d", i), vecs[i].unl, vecs[i].led,
                  vecs[i].lk, vecs[i].pg, vecs[i].sd, vecs[i].ec);
        end

        // three failures into lockout
        enter(24'h570164);
        check("fail1", 0, 1, 0, 0, 2'b01, 2'd1);
        enter(24'h570164);
        check("fail2", 0, 1, 0, 0, 2'b01, 2'd2);
        enter(24'h570164);
        check("lock_enter", 0, 1, 1, 0, 2'b11, 2'd3);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("lock_cyc%0d", i), 0, 1, 1, 0, 2'b11, 2'd3);
            apply(1'b1, dflt[i % 6], (i % 3) == 1, (i % 3) == 2);
        end
        check("lock_exit", 0, 0, 0, 0, 2'b00, 2'd0);
        enter(24'h575164);
        check("open_after_lock", 1, 0, 0, 0, 2'b10, 2'd0);

        // reprogram to 1,2,3,4,5,6
        apply(1'b0, 4'd0, 1'b0, 1'b1);
        check("prog_enter", 0, 0, 0, 1, 2'b10, 2'd0);
        enter(24'h123456);
        check("prog_done", 0, 0, 0, 0, 2'b00, 2'd0);
        enter(24'h575164);
        check("old_code_fails", 0, 1, 0, 0, 2'b01, 2'd1);
        enter(24'h123456);
        check("new_code_opens", 1, 0, 0, 0, 2'b10, 2'd0);

        // aborted programming keeps the current code
        apply(1'b0, 4'd0, 1'b0, 1'b1);
        apply(1'b1, 4'd1, 1'b0, 1'b0);
        apply(1'b1, 4'd2, 1'b0, 1'b0);
        apply(1'b1, 4'd9, 1'b0, 1'b0);
        apply(1'b0, 4'd0, 1'b1, 1'b0);
        check("prog_abort", 0, 0, 0, 0, 2'b00, 2'd0);
        enter(24'h123456);
        check("code_kept", 1, 0, 0, 0, 2'b10, 2'd0);

        // reset in the middle of programming
        apply(1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            apply(1'b1, 4'd7, 1'b0, 1'b0);
        check("prog_mid", 0, 0, 0, 1, 2'b10, 2'd0);
        reset_n = 1'b0;
        #1;
        check("reset_mid_prog", 0, 0, 0, 0, 2'b00, 2'd0);
        @(negedge clock);
        reset_n = 1'b1;
        enter(24'h575164);
        check("default_after_reset", 1, 0, 0, 0, 2'b10, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
